sram_controller: RTL and testbench

Memory-side responder for the MEM stage's `ready` handshake. It accepts one 32-bit read or write request from the pipeline and performs it as two 16-bit accesses on an external asynchronous SRAM. It holds `ready` low until the access completes, which freezes the pipeline for the duration. It sits between the MEM stage and the board SRAM pins, and it is the sole source of `MEM_ready`.

---
 rtl/sram_controller_if.sv | 13 +
 rtl/sram_controller.sv | 98 +++++++++
 tb/tb_sram_controller.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_if.sv
// MEM-stage request/response bundle between the pipeline and sram_controller.
// The pipeline drives the request side; the controller returns read data and ready.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (output wr_en, rd_en, address, write_data, input read_data, ready);
  modport slave  (input wr_en, rd_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_controller.sv
// Splits one 32-bit MEM-stage load/store into two 16-bit async-SRAM accesses,
// holding ready low (stalling the pipeline) until the access completes.
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  sram_controller_if.slave  bus,
  inout  wire  [15:0]       SRAM_DQ,
  output logic [17:0]       SRAM_ADDR,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N
);
  typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAST_CNT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_is_wr;
  logic [16:0] r_word;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        w_req;
  logic        w_drive;
  logic [15:0] w_dq_out;

  assign w_req = bus.wr_en | bus.rd_en;

  always_comb begin
    w_next    = r_state;
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    w_drive   = 1'b0;
    w_dq_out  = r_wdata[15:0];
    case (r_state)
      S_IDLE: if (w_req) w_next = S_LOW;
      S_LOW: begin
        w_next    = S_HIGH;
        SRAM_ADDR = {r_word, 1'b0};
        SRAM_WE_N = ~r_is_wr;
        w_drive   = r_is_wr;
      end
      S_HIGH: begin
        w_next    = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
        SRAM_ADDR = {r_word, 1'b1};
        SRAM_WE_N = ~r_is_wr;
        w_drive   = r_is_wr;
        w_dq_out  = r_wdata[31:16];
      end
      S_WAIT: if (r_cnt == LAST_CNT) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_HIGH)
        r_cnt <= '0;
      else if (r_state == S_WAIT)
        r_cnt <= r_cnt + 4'd1;
      // SRAM data is sampled at the end of the address-stable cycle
      if (r_state == S_LOW && !r_is_wr)
        r_rdata[15:0] <= SRAM_DQ;
      if (r_state == S_HIGH && !r_is_wr)
        r_rdata[31:16] <= SRAM_DQ;
    end
  end

  // Request is latched once on leaving IDLE; write wins over read
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_req) begin
      r_is_wr <= bus.wr_en;
      r_word  <= 17'((bus.address - BASE_ADDR) >> 2);
      r_wdata <= bus.write_data;
    end
  end

  assign SRAM_DQ       = w_drive ? w_dq_out : 16'bz;
  assign bus.ready     = (r_state == S_IDLE && !w_req) || (r_state == S_DONE);
  assign bus.read_data = r_rdata;

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: default build and WAIT_CYCLES=0 build, each on its
// own behavioural async-SRAM; random traffic is checked against a word-level model.
module tb_sram_controller;
  localparam logic [31:0] BASE = 32'd1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_controller_if bus0();
  sram_controller_if bus1();

  wire  [15:0] dq0, dq1;
  logic [17:0] a0, a1;
  logic        we0, we1;
  logic        ub0, lb0, ce0, oe0, ub1, lb1, ce1, oe1;

  sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(3)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .SRAM_DQ(dq0), .SRAM_ADDR(a0), .SRAM_WE_N(we0),
    .SRAM_UB_N(ub0), .SRAM_LB_N(lb0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0));

  sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .SRAM_DQ(dq1), .SRAM_ADDR(a1), .SRAM_WE_N(we1),
    .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1));

  // Async SRAM models: never-written halfwords read back an address-derived pattern
  logic [15:0] mem0 [0:262143];
  logic [15:0] mem1 [0:262143];
  bit          wf0  [0:262143];
  bit          wf1  [0:262143];
  logic [15:0] m0v, m1v;

  function automatic logic [15:0] dflt(input logic [17:0] a);
    return (16'(a) * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] m0(input logic [17:0] a);
    return wf0[a] ? mem0[a] : dflt(a);
  endfunction

  function automatic logic [15:0] m1(input logic [17:0] a);
    return wf1[a] ? mem1[a] : dflt(a);
  endfunction

  assign m0v = m0(a0);
  assign m1v = m1(a1);
  assign dq0 = we0 ? m0v : 16'hzzzz;
  assign dq1 = we1 ? m1v : 16'hzzzz;

  always @(posedge clk) begin
    if (!we0) begin mem0[a0] <= dq0; wf0[a0] <= 1'b1; end
    if (!we1) begin mem1[a1] <= dq1; wf1[a1] <= 1'b1; end
  end

  int checks = 0;
  int failures = 0;

  logic        lg_rdy [0:63];
  logic [17:0] lg_addr[0:63];
  logic        lg_we  [0:63];
  logic [15:0] lg_dq  [0:63];
  logic [31:0] lg_rd  [0:63];

  logic [31:0] ref_w [int];

  task automatic set_in(input int sel, input bit wr, input bit rd,
                        input logic [31:0] a, input logic [31:0] wd);
    if (sel == 0) begin
      bus0.wr_en = wr; bus0.rd_en = rd; bus0.address = a; bus0.write_data = wd;
    end else begin
      bus1.wr_en = wr; bus1.rd_en = rd; bus1.address = a; bus1.write_data = wd;
    end
  endtask

  // Drives one request starting now (just after a rising edge), logs each cycle,
  // and returns one cycle after DONE with the request withdrawn.
  task automatic do_req(input int sel, input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] wd, input int chg_cyc, output int done_cyc);
    done_cyc = -1;
    set_in(sel, wr, rd, a, wd);
    for (int k = 0; k < 40; k++) begin
      if (k == chg_cyc) set_in(sel, wr, rd, 32'd1100, 32'd0);
      @(negedge clk);
      lg_rdy[k]  = (sel == 0) ? bus0.ready     : bus1.ready;
      lg_addr[k] = (sel == 0) ? a0             : a1;
      lg_we[k]   = (sel == 0) ? we0            : we1;
      lg_dq[k]   = (sel == 0) ? dq0            : dq1;
      lg_rd[k]   = (sel == 0) ? bus0.read_data : bus1.read_data;
      if (lg_rdy[k] === 1'b1 && k > 0) begin
        done_cyc = k;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    set_in(sel, 1'b0, 1'b0, a, wd);
  endtask

  function automatic int low_count(input int d);
    int n = 0;
    if (d < 0) return -1;
    for (int k = 0; k <= d; k++) if (lg_rdy[k] === 1'b0) n++;
    return n;
  endfunction

  task automatic test_reset;
    #3;
    rst = 1'b1;
    #1;
    checks++; if (bus0.ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", bus0.ready); end
    checks++; if (bus0.read_data !== 32'd0) begin failures++; $display("FAIL rst_rdata got=%0h exp=0", bus0.read_data); end
    checks++; if (we0 !== 1'b1) begin failures++; $display("FAIL rst_we_n got=%0b exp=1", we0); end
    checks++; if (a0 !== 18'd0) begin failures++; $display("FAIL rst_addr got=%0h exp=0", a0); end
    checks++; if (dq0 !== dflt(18'd0)) begin failures++; $display("FAIL rst_dq_released got=%0h exp=%0h", dq0, dflt(18'd0)); end
    checks++; if (bus1.ready !== 1'b1) begin failures++; $display("FAIL rst_ready_w0 got=%0b exp=1", bus1.ready); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_default;
    int d;
    do_req(0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, -1, d);
    checks++; if (d !== 6) begin failures++; $display("FAIL wr_done_cycle got=%0d exp=6", d); end
    checks++; if (low_count(d) !== 6) begin failures++; $display("FAIL wr_stall got=%0d exp=6", low_count(d)); end
    checks++; if (lg_addr[1] !== 18'd2 || lg_dq[1] !== 16'hBEEF || lg_we[1] !== 1'b0) begin
      failures++; $display("FAIL wr_low_access got=addr %0h dq %0h we %0b exp=addr 2 dq beef we 0", lg_addr[1], lg_dq[1], lg_we[1]); end
    checks++; if (lg_addr[2] !== 18'd3 || lg_dq[2] !== 16'hDEAD || lg_we[2] !== 1'b0) begin
      failures++; $display("FAIL wr_high_access got=addr %0h dq %0h we %0b exp=addr 3 dq dead we 0", lg_addr[2], lg_dq[2], lg_we[2]); end
    checks++; if (m0(18'd2) !== 16'hBEEF || m0(18'd3) !== 16'hDEAD) begin
      failures++; $display("FAIL wr_sram_contents got=%0h_%0h exp=dead_beef", m0(18'd3), m0(18'd2)); end
    checks++; if (lg_rd[6] !== 32'd0) begin failures++; $display("FAIL wr_keeps_rdata got=%0h exp=0", lg_rd[6]); end
  endtask

  task automatic test_readback;
    int d;
    bit we_ok = 1'b1;
    do_req(0, 1'b0, 1'b1, 32'd1028, 32'h0, -1, d);
    for (int k = 0; k <= d; k++) if (lg_we[k] !== 1'b1) we_ok = 1'b0;
    checks++; if (lg_rdy[0] !== 1'b0) begin failures++; $display("FAIL rb_no_bubble got=%0b exp=0", lg_rdy[0]); end
    checks++; if (d !== 6) begin failures++; $display("FAIL rb_done_cycle got=%0d exp=6", d); end
    checks++; if (!we_ok) begin failures++; $display("FAIL rb_we_n_high got=0 exp=1"); end
    checks++; if (d >= 0 && lg_rd[d] !== 32'hDEADBEEF) begin failures++; $display("FAIL rb_rdata got=%0h exp=deadbeef", lg_rd[d]); end
    @(negedge clk);
    checks++; if (bus0.read_data !== 32'hDEADBEEF) begin failures++; $display("FAIL rb_rdata_hold got=%0h exp=deadbeef", bus0.read_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_priority;
    int d;
    logic [31:0] prev = bus0.read_data;
    logic [15:0] o38 = m0(18'd38);
    logic [15:0] o39 = m0(18'd39);
    do_req(0, 1'b1, 1'b1, 32'd1032, 32'h12345678, 2, d);
    checks++; if (d !== 6) begin failures++; $display("FAIL pri_done_cycle got=%0d exp=6", d); end
    checks++; if (m0(18'd4) !== 16'h5678 || m0(18'd5) !== 16'h1234) begin
      failures++; $display("FAIL pri_sram_contents got=%0h_%0h exp=1234_5678", m0(18'd5), m0(18'd4)); end
    checks++; if (m0(18'd38) !== o38 || m0(18'd39) !== o39) begin
      failures++; $display("FAIL pri_late_addr_ignored got=%0h_%0h exp=%0h_%0h", m0(18'd39), m0(18'd38), o39, o38); end
    checks++; if (bus0.read_data !== prev) begin failures++; $display("FAIL pri_rdata_kept got=%0h exp=%0h", bus0.read_data, prev); end
  endtask

  task automatic test_reset_midop;
    int d;
    set_in(0, 1'b0, 1'b1, 32'd1032, 32'h0);
    repeat (4) begin @(posedge clk); #1; end
    #3;
    set_in(0, 1'b0, 1'b0, 32'd1032, 32'h0);
    rst = 1'b1;
    #1;
    checks++; if (bus0.ready !== 1'b1) begin failures++; $display("FAIL mrst_ready got=%0b exp=1", bus0.ready); end
    checks++; if (bus0.read_data !== 32'd0) begin failures++; $display("FAIL mrst_rdata got=%0h exp=0", bus0.read_data); end
    checks++; if (we0 !== 1'b1 || a0 !== 18'd0) begin failures++; $display("FAIL mrst_pins got=we %0b addr %0h exp=we 1 addr 0", we0, a0); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    do_req(0, 1'b0, 1'b1, 32'd1032, 32'h0, -1, d);
    checks++; if (d !== 6) begin failures++; $display("FAIL mrst_next_done got=%0d exp=6", d); end
    checks++; if (bus0.read_data !== 32'h12345678) begin failures++; $display("FAIL mrst_next_rdata got=%0h exp=12345678", bus0.read_data); end
  endtask

  task automatic test_wait0;
    int d;
    logic [31:0] exp0 = {m1(18'd1), m1(18'd0)};
    do_req(1, 1'b0, 1'b1, 32'd1024, 32'h0, -1, d);
    checks++; if (d !== 3) begin failures++; $display("FAIL w0_rd_done got=%0d exp=3", d); end
    checks++; if (low_count(d) !== 3) begin failures++; $display("FAIL w0_rd_stall got=%0d exp=3", low_count(d)); end
    checks++; if (bus1.read_data !== exp0) begin failures++; $display("FAIL w0_rdata got=%0h exp=%0h", bus1.read_data, exp0); end
    do_req(1, 1'b1, 1'b0, 32'd1040, 32'hCAFEF00D, -1, d);
    checks++; if (d !== 3) begin failures++; $display("FAIL w0_wr_done got=%0d exp=3", d); end
    do_req(1, 1'b0, 1'b1, 32'd1040, 32'h0, -1, d);
    checks++; if (bus1.read_data !== 32'hCAFEF00D) begin failures++; $display("FAIL w0_readback got=%0h exp=cafef00d", bus1.read_data); end
  endtask

  // Word-level reference: each 32-bit word lives at halfwords 2*idx (low) and 2*idx+1 (high)
  task automatic test_random;
    int pool[6];
    int d;
    for (int i = 0; i < 6; i++) pool[i] = int'($urandom_range(0, 131071));
    for (int n = 0; n < 30; n++) begin
      int idx = pool[$urandom_range(0, 5)];
      logic [31:0] off  = {13'($urandom), 17'(idx), 2'($urandom)};
      logic [31:0] addr = off + BASE;
      logic [31:0] wd   = $urandom;
      bit do_wr = !ref_w.exists(idx) || ($urandom_range(0, 1) == 1);
      logic [31:0] prev = bus0.read_data;
      do_req(0, do_wr, do_wr ? 1'($urandom) : 1'b1, addr, wd, -1, d);
      checks++; if (d !== 6) begin failures++; $display("FAIL rnd_done op=%0d got=%0d exp=6", n, d); end
      if (do_wr) begin
        ref_w[idx] = wd;
        checks++; if ({m0(18'(2*idx+1)), m0(18'(2*idx))} !== wd || bus0.read_data !== prev) begin
          failures++; $display("FAIL rnd_write op=%0d got=%0h rdata %0h exp=%0h rdata %0h",
                               n, {m0(18'(2*idx+1)), m0(18'(2*idx))}, bus0.read_data, wd, prev); end
      end else begin
        checks++; if (bus0.read_data !== ref_w[idx]) begin
          failures++; $display("FAIL rnd_read op=%0d got=%0h exp=%0h", n, bus0.read_data, ref_w[idx]); end
      end
    end
  endtask

  initial begin
    set_in(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_in(1, 1'b0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_write_default();
    test_readback();
    test_priority();
    test_reset_midop();
    test_wait0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
